// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding, opcodes
// and the select/operation encodings it drives toward the datapath.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == RTYPE) || (op == LW) || (op == SW) ||
           (op == BEQ) || (op == ADDI) || (op == J);
  endfunction

endpackage

// File: rtl/mc_controller.sv
// Moore control FSM for a multicycle MIPS-style datapath; outputs decode from
// the current state, with pcen additionally qualified by the ALU zero flag.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic [1:0] aluop,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pcen,
  output logic       illegal
);

  state_t state_reg;
  state_t state_next;
  logic   illegal_reg;
  logic   pcwrite;
  logic   branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE && !op_supported(op))
        illegal_reg <= 1'b1;
    end
  end

  assign illegal = illegal_reg;

  // op is only looked at while decoding and while picking load vs. store
  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:   state_next = DECODE;
      DECODE: begin
        case (op)
          LW, SW:  state_next = MEMADR;
          RTYPE:   state_next = RTYPEEX;
          BEQ:     state_next = BEQEX;
          ADDI:    state_next = ADDIEX;
          J:       state_next = JEX;
          default: state_next = FETCH;
        endcase
      end
      MEMADR:  state_next = (op == LW) ? MEMRD : MEMWR;
      MEMRD:   state_next = MEMWB;
      RTYPEEX: state_next = RTYPEWB;
      ADDIEX:  state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    aluop    = ALUOP_ADD;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REGB;
    pcsrc    = PCSRC_ALU;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (state_reg)
      FETCH: begin
        alusrcb = SRCB_FOUR;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE:  alusrcb = SRCB_IMMSH;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      ADDIWB:  regwrite = 1'b1;
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: expected per-cycle output vectors are
// queued when an instruction is issued and compared cycle by cycle.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic [1:0] aluop;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       pcen;
  logic       illegal;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [14:0] exp_q[$];
  logic        ill_model = 1'b0;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                 S_MEMWB = 4, S_MEMWR = 5, S_RTEX = 6, S_RTWB = 7,
                 S_BEQ = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JEX = 11;

  mc_controller dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .zero     (zero),
    .aluop    (aluop),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .iord     (iord),
    .irwrite  (irwrite),
    .memwrite (memwrite),
    .regwrite (regwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .pcen     (pcen),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  // {aluop, alusrca, alusrcb, pcsrc, iord, irwrite, memwrite, regwrite, regdst, memtoreg, pcen, illegal}
  wire [14:0] actual = {aluop, alusrca, alusrcb, pcsrc, iord, irwrite, memwrite,
                        regwrite, regdst, memtoreg, pcen, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [14:0] exp_vec(input int s, input logic z, input logic ill);
    logic [1:0] a_op = 2'b00, srcb = 2'b00, psrc = 2'b00;
    logic srca = 0, io = 0, irw = 0, mw = 0, rw = 0, rd = 0, m2r = 0, pe = 0;
    case (s)
      S_FETCH:  begin srcb = 2'b01; irw = 1; pe = 1; end
      S_DECODE: srcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin srca = 1; srcb = 2'b10; end
      S_MEMRD:  io = 1;
      S_MEMWB:  begin m2r = 1; rw = 1; end
      S_MEMWR:  begin io = 1; mw = 1; end
      S_RTEX:   begin srca = 1; a_op = 2'b10; end
      S_RTWB:   begin rd = 1; rw = 1; end
      S_ADDIWB: rw = 1;
      S_BEQ:    begin srca = 1; a_op = 2'b01; psrc = 2'b01; pe = z; end
      S_JEX:    begin psrc = 2'b10; pe = 1; end
      default: ;
    endcase
    return {a_op, srca, srcb, psrc, io, irw, mw, rw, rd, m2r, pe, ill};
  endfunction

  // Issue one instruction starting in FETCH; limit > 0 stops early and stays in
  // the last checked state instead of returning to FETCH.
  task automatic run_instr(input string name, input logic [5:0] o, input logic z,
                           input int limit);
    int seq[$];
    int n;
    logic ill;
    logic [14:0] e;
    seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    case (o)
      6'b100011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMRD); seq.push_back(S_MEMWB); end
      6'b101011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMWR); end
      6'b000000: begin seq.push_back(S_RTEX); seq.push_back(S_RTWB); end
      6'b000100: seq.push_back(S_BEQ);
      6'b001000: begin seq.push_back(S_ADDIEX); seq.push_back(S_ADDIWB); end
      6'b000010: seq.push_back(S_JEX);
      default: ;
    endcase
    n = (limit > 0 && limit < seq.size()) ? limit : seq.size();
    op   = o;
    zero = z;
    ill  = ill_model;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_vec(seq[i], z, ill));
      if (seq[i] == S_DECODE && seq.size() == 2) ill = 1'b1;
    end
    ill_model = ill;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s c%0d", name, i + 1), {17'd0, actual}, {17'd0, e});
      if (i < n - 1 || limit <= 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    zero  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset vec", {17'd0, actual}, {17'd0, exp_vec(S_FETCH, 1'b0, 1'b0)});
    reset = 1'b0;
    #1;
    run_instr("lw", 6'b100011, 1'b1, 0);
    run_instr("sw", 6'b101011, 1'b0, 0);
    run_instr("rtype", 6'b000000, 1'b1, 0);
    run_instr("beq z1", 6'b000100, 1'b1, 0);
    run_instr("beq z0", 6'b000100, 1'b0, 0);
    run_instr("addi", 6'b001000, 1'b0, 0);
    run_instr("bad op", 6'b111111, 1'b0, 0);
    run_instr("j", 6'b000010, 1'b0, 0);
    run_instr("bad op2", 6'b100000, 1'b1, 0);
    run_instr("rtype2", 6'b000000, 1'b0, 0);
    // stop in MEMRD, then hit reset between clock edges
    run_instr("lw part", 6'b100011, 1'b0, 4);
    #2 reset = 1'b1;
    #1;
    ill_model = 1'b0;
    check("async rst vec", {17'd0, actual}, {17'd0, exp_vec(S_FETCH, 1'b0, 1'b0)});
    check("async rst ill", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    run_instr("j post rst", 6'b000010, 1'b1, 0);
    run_instr("lw post rst", 6'b100011, 1'b0, 0);
    check("queue empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
